gpio_port: RTL and testbench
============================

GPIO_PORT -- requirements
Module: gpio_port

Interface
REQ-001 Parameter PORT_NUM, default 1, range 1..64: number of 32-bit GPIO ports.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 addrIn  input  8  word address of the write target.
REQ-005 addrOut  input  8  word address of the read source.
REQ-006 sizeDecode  input  4  byte-lane write enables; bit k enables dataIn[8k+7:8k]; 0000 means no write.
REQ-007 dataIn  input  32  write data.
REQ-008 dataOut  output  32  read data.
REQ-009 ioPin  inout  32*PORT_NUM  pad pins; port p occupies bits [32p+31:32p].

Function
REQ-010 Register map, port p, word address 4p+r:
- r=0 OUT: read/write output value.
- r=1 IN: read-only pin value.
- r=2 DIR: read/write direction, 1 = output.
- r=3 TGL: write-only; written bits XOR into OUT; reads 0.
REQ-011 Writes occur on the rising clk edge, only on lanes whose sizeDecode bit is 1; unselected lanes keep their value.
REQ-012 Writes to IN, to TGL lanes with sizeDecode=0, and to addresses >= 4*PORT_NUM are ignored.
REQ-013 dataOut is combinational from addrOut and current register/pin state, with zero-cycle latency.
REQ-014 Reads of unmapped addresses (>= 4*PORT_NUM) return 0x00000000.
REQ-015 Pin drive per bit: ioPin bit = OUT bit when the DIR bit is 1, else high-impedance.
REQ-016 IN reflects ioPin for every bit regardless of DIR; an output bit reads back its pad level.
REQ-017 Simultaneous write and read of the same register: dataOut shows the old value until the write edge, then the new value.
REQ-018 Writing addresses never affects other ports' registers.

Reset
REQ-019 rstn low asynchronously clears OUT and DIR of all ports to 0, so every pin is high-impedance.
REQ-020 rstn low clears the synchronizer flops (when present) to 0.
REQ-021 Registers hold reset values until the first rising clk edge after rstn deasserts.
REQ-022 rstn asserted mid-write: the write is lost and reset values win.

Configuration
REQ-023 Macro GPIO_INPUT_SYNC_EN:
- Defined: IN is sampled through a two-flop synchronizer per bit, giving 2-cycle latency from pin change to IN read.
- Undefined: IN is the combinational pin value, with zero latency.

Verification
REQ-024 Reset, then read addrOut=0 and addrOut=2 -> dataOut=0x00000000; ioPin all Z (bench pull observed).
REQ-025 Write addrIn=0 with 0x00550055, sizeDecode=1111; then addrIn=2 with 0x00550055; then read addrOut=2 -> 0x00550055, read addrOut=0 -> 0x00550055; pins with DIR=1 drive OUT, others are Z.
REQ-026 Bench drives ioPin=0xFFFFFFFF on input bits; read addrOut=1 -> 0xFFFFFFFF (macro defined: after 2 cycles); write addrIn=1 with 0xFFFFFFFF -> OUT/DIR unchanged.
REQ-027 Write addrIn=0 with 0x12345678 and sizeDecode=0101 over OUT=0 -> OUT=0x00340078; sizeDecode=0000 -> no change.
REQ-028 With OUT=0x00550055, write TGL (addrIn=3) with 0xFFFF0000 -> OUT=0xFFAA0055; read addrOut=3 -> 0.
REQ-029 Assert rstn mid-sequence with DIR=0xFFFFFFFF -> OUT=DIR=0 immediately without a clock edge, pins Z; read addrOut=8 with PORT_NUM=1 -> 0.

Source files
------------

// File: rtl/gpio_port.sv
// gpio_port: memory-mapped GPIO ports with per-bit direction, toggle register and optional input sync
// Ports: clk/rstn clock and async active-low reset; addrIn/sizeDecode/dataIn byte-lane write;
//        addrOut/dataOut combinational read; ioPin tri-state pads, 32 per port.
// Map per port p at word 4p+r: r=0 OUT, r=1 IN (ro), r=2 DIR (1=drive), r=3 TGL (wo, XOR into OUT).
// Macro GPIO_INPUT_SYNC_EN: IN passes through a two-flop synchronizer instead of reading pads directly.
module gpio_port #(
  parameter int PORT_NUM = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            addrIn,
  input  logic [7:0]            addrOut,
  input  logic [3:0]            sizeDecode,
  input  logic [31:0]           dataIn,
  output logic [31:0]           dataOut,
  inout  wire  [32*PORT_NUM-1:0] ioPin
);
  logic [31:0] w_mask;
  logic [31:0] w_out [PORT_NUM];
  logic [31:0] w_dir [PORT_NUM];
  logic [31:0] w_in  [PORT_NUM];
  assign w_mask = {{8{sizeDecode[3]}}, {8{sizeDecode[2]}}, {8{sizeDecode[1]}}, {8{sizeDecode[0]}}};
  genvar p, b;
  generate
    for (p = 0; p < PORT_NUM; p++) begin : g_port
      logic [31:0] r_out, r_dir;
      logic        w_sel;
      // addresses beyond the last port match no p, so they are dropped here
      assign w_sel = (addrIn[7:2] == 6'(p)) && |sizeDecode;
      always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
          r_out <= '0;
          r_dir <= '0;
        end else if (w_sel) begin
          r_out <= addrIn[1:0] == 2'd0 ? (r_out & ~w_mask) | (dataIn & w_mask) :
                   addrIn[1:0] == 2'd3 ? r_out ^ (dataIn & w_mask) : r_out;
          r_dir <= addrIn[1:0] == 2'd2 ? (r_dir & ~w_mask) | (dataIn & w_mask) : r_dir;
        end
`ifdef GPIO_INPUT_SYNC_EN
      logic [31:0] r_s1, r_s2;
      always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
          r_s1 <= '0;
          r_s2 <= '0;
        end else begin
          r_s1 <= ioPin[32*p +: 32];
          r_s2 <= r_s1;
        end
      assign w_in[p] = r_s2;
`else
      assign w_in[p] = ioPin[32*p +: 32];
`endif
      assign w_out[p] = r_out;
      assign w_dir[p] = r_dir;
      for (b = 0; b < 32; b++) begin : g_bit
        assign ioPin[32*p+b] = r_dir[b] ? r_out[b] : 1'bz;
      end
    end
  endgenerate
  always_comb begin
    dataOut = '0;
    for (int i = 0; i < PORT_NUM; i++)
      if (addrOut[7:2] == 6'(i))
        dataOut = addrOut[1:0] == 2'd0 ? w_out[i] :
                  addrOut[1:0] == 2'd1 ? w_in[i]  :
                  addrOut[1:0] == 2'd2 ? w_dir[i] : '0;
  end
endmodule

// File: tb/tb_gpio_port.sv
// tb_gpio_port: table-driven scoreboard bench for gpio_port with two ports
module tb_gpio_port;
  localparam int P = 2;
  logic        clk = 0;
  logic        rstn = 0;
  logic [7:0]  addrIn = 0;
  logic [7:0]  addrOut = 0;
  logic [3:0]  sizeDecode = 0;
  logic [31:0] dataIn = 0;
  wire  [31:0] dataOut;
  wire  [63:0] ioPin;
  logic [63:0] tbv = 64'hA5A50F0F_3C3CC3C3;
  logic [31:0] m_out [P] = '{default: 0};
  logic [31:0] m_dir [P] = '{default: 0};
  wire  [63:0] w_en = ~{m_dir[1], m_dir[0]};
  int n_run = 0;
  int n_fail = 0;
  logic [31:0] q_exp[$];
  typedef struct {
    logic [7:0]  wa;
    logic [3:0]  sd;
    logic [31:0] wd;
    logic [7:0]  ra;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[26];
  always #5 clk = ~clk;
  genvar i;
  for (i = 0; i < 64; i++) begin : g_drv
    assign ioPin[i] = w_en[i] ? tbv[i] : 1'bz;
  end
  gpio_port #(.PORT_NUM(P)) dut (
    .clk(clk), .rstn(rstn), .addrIn(addrIn), .addrOut(addrOut),
    .sizeDecode(sizeDecode), .dataIn(dataIn), .dataOut(dataOut), .ioPin(ioPin)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic sample(input string nm);
    logic [31:0] e;
    if (q_exp.size() == 0) begin
      n_run++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = q_exp.pop_front();
      chk(nm, dataOut, e);
    end
  endtask
  task automatic expect_rd(input string nm, input logic [7:0] ra, input logic [31:0] e);
    addrOut = ra;
    q_exp.push_back(e);
    #1 sample(nm);
  endtask
  task automatic chk_pins(input string nm);
    for (int p = 0; p < P; p++)
      chk(nm, ioPin[32*p +: 32], (m_dir[p] & m_out[p]) | (~m_dir[p] & tbv[32*p +: 32]));
  endtask
  task automatic mwrite(input logic [7:0] wa, input logic [3:0] sd, input logic [31:0] wd);
    logic [31:0] m;
    int p;
    m = {{8{sd[3]}}, {8{sd[2]}}, {8{sd[1]}}, {8{sd[0]}}};
    p = int'(wa[2]);
    if (sd != 0 && wa < 8) begin
      if (wa[1:0] == 2'd0) m_out[p] = (m_out[p] & ~m) | (wd & m);
      if (wa[1:0] == 2'd2) m_dir[p] = (m_dir[p] & ~m) | (wd & m);
      if (wa[1:0] == 2'd3) m_out[p] = m_out[p] ^ (wd & m);
    end
  endtask
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    addrIn = v.wa;
    sizeDecode = v.sd;
    dataIn = v.wd;
    @(posedge clk);
    mwrite(v.wa, v.sd, v.wd);
    #1 sizeDecode = 0;
    addrOut = v.ra;
    q_exp.push_back(v.exp);
`ifdef GPIO_INPUT_SYNC_EN
    repeat (2) @(posedge clk);
    #1;
`endif
    #1 sample($sformatf("vec%0d", idx));
    chk_pins($sformatf("pins%0d", idx));
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] old_in, new_in;
    vt[0]  = '{8'h00, 4'h0, 32'h0,        8'h00, 32'h00000000};
    vt[1]  = '{8'h00, 4'h0, 32'h0,        8'h02, 32'h00000000};
    vt[2]  = '{8'h00, 4'h0, 32'h0,        8'h01, 32'h3C3CC3C3};
    vt[3]  = '{8'h00, 4'hF, 32'h00550055, 8'h00, 32'h00550055};
    vt[4]  = '{8'h02, 4'hF, 32'h00550055, 8'h02, 32'h00550055};
    vt[5]  = '{8'h00, 4'h0, 32'h0,        8'h01, 32'h3C7DC3D7};
    vt[6]  = '{8'h01, 4'hF, 32'hFFFFFFFF, 8'h00, 32'h00550055};
    vt[7]  = '{8'h00, 4'h0, 32'h0,        8'h02, 32'h00550055};
    vt[8]  = '{8'h00, 4'hF, 32'h00000000, 8'h00, 32'h00000000};
    vt[9]  = '{8'h00, 4'h5, 32'h12345678, 8'h00, 32'h00340078};
    vt[10] = '{8'h00, 4'h0, 32'hFFFFFFFF, 8'h00, 32'h00340078};
    vt[11] = '{8'h00, 4'hF, 32'h00550055, 8'h00, 32'h00550055};
    vt[12] = '{8'h03, 4'hF, 32'hFFFF0000, 8'h00, 32'hFFAA0055};
    vt[13] = '{8'h00, 4'h0, 32'h0,        8'h03, 32'h00000000};
    vt[14] = '{8'h03, 4'h0, 32'hFFFFFFFF, 8'h00, 32'hFFAA0055};
    vt[15] = '{8'h03, 4'h1, 32'h000000FF, 8'h00, 32'hFFAA00AA};
    vt[16] = '{8'h04, 4'hF, 32'hDEADBEEF, 8'h00, 32'hFFAA00AA};
    vt[17] = '{8'h00, 4'h0, 32'h0,        8'h04, 32'hDEADBEEF};
    vt[18] = '{8'h06, 4'hF, 32'h0000FFFF, 8'h06, 32'h0000FFFF};
    vt[19] = '{8'h00, 4'h0, 32'h0,        8'h05, 32'hA5A5BEEF};
    vt[20] = '{8'h08, 4'hF, 32'h12345678, 8'h08, 32'h00000000};
    vt[21] = '{8'h00, 4'h0, 32'h0,        8'h02, 32'h00550055};
    vt[22] = '{8'h00, 4'h0, 32'h0,        8'h00, 32'hFFAA00AA};
    vt[23] = '{8'hFF, 4'hF, 32'hFFFFFFFF, 8'h0C, 32'h00000000};
    vt[24] = '{8'h00, 4'h0, 32'h0,        8'h07, 32'h00000000};
    vt[25] = '{8'h00, 4'h0, 32'h0,        8'h01, 32'h3C28C382};
    #1 expect_rd("rst_out", 8'h00, 32'h0);
    expect_rd("rst_dir", 8'h02, 32'h0);
    chk_pins("rst_pins");
    @(negedge clk);
    @(negedge clk) rstn = 1;
    for (int k = 0; k < 26; k++) apply(vt[k], k);
    // read and write of the same register in one cycle
    @(negedge clk);
    addrIn = 8'h04;
    sizeDecode = 4'hF;
    dataIn = 32'h0BADF00D;
    expect_rd("rdw_old", 8'h04, 32'hDEADBEEF);
    @(posedge clk);
    mwrite(8'h04, 4'hF, 32'h0BADF00D);
    #1 sizeDecode = 0;
    expect_rd("rdw_new", 8'h04, 32'h0BADF00D);
    // input path latency after a pad change on input bits
    @(negedge clk);
    old_in = (m_dir[0] & m_out[0]) | (~m_dir[0] & tbv[31:0]);
    tbv[31:0] = 32'hFFFFFFFF;
    new_in = m_dir[0] & m_out[0] | ~m_dir[0];
`ifdef GPIO_INPUT_SYNC_EN
    expect_rd("in_sync0", 8'h01, old_in);
    @(posedge clk);
    #1 expect_rd("in_sync1", 8'h01, old_in);
    @(posedge clk);
    #1 expect_rd("in_sync2", 8'h01, new_in);
`else
    chk("in_prev", old_in, 32'h3C28C382);
    expect_rd("in_comb", 8'h01, new_in);
`endif
    chk_pins("pins_ff");
    // async reset in the middle of a pending write
    apply('{8'h02, 4'hF, 32'hFFFFFFFF, 8'h02, 32'hFFFFFFFF}, 99);
    @(negedge clk);
    addrIn = 8'h00;
    sizeDecode = 4'hF;
    dataIn = 32'h12345678;
    #2 rstn = 0;
    m_out = '{default: 0};
    m_dir = '{default: 0};
    #1 expect_rd("arst_dir", 8'h02, 32'h0);
    expect_rd("arst_out", 8'h00, 32'h0);
    expect_rd("arst_p1", 8'h04, 32'h0);
    chk_pins("arst_pins");
    @(posedge clk);
    #1 expect_rd("arst_hold", 8'h00, 32'h0);
    @(negedge clk);
    rstn = 1;
    sizeDecode = 0;
    @(posedge clk);
    #1 expect_rd("post_rst_out", 8'h00, 32'h0);
    expect_rd("post_rst_dir", 8'h02, 32'h0);
    expect_rd("unmapped8", 8'h08, 32'h0);
    chk_pins("post_rst_pins");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
